ip_tx_arp_resolve: RTL and testbench

//  Width-parametrised IP transmit-side next-hop resolver: takes an IP header + AXI-stream payload,

---
 rtl/ip_tx_arp_resolve.sv | 140 ++++++++++++++
 tb/tb_ip_tx_arp_resolve.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_tx_arp_resolve.sv
// ip_tx_arp_resolve: IP TX next-hop resolver. Resolves dest_ip through ARP, then emits the header
// augmented with Ethernet dest/src MAC and type 0x0800, followed by the payload. Drops on ARP failure.
// Ports: clk, rst_n (async, active-low); s_ip_hdr_* / s_ip_payload_axis_* input frame;
//        arp_request_* / arp_response_* lookup interface; m_ip_hdr_* / m_ip_payload_axis_* output frame;
//        local_mac (sampled with the header); busy; error_arp_failed / error_arp_timeout one-cycle pulses.
// Optional: define IP_TX_ARP_TIMEOUT_EN to abandon lookups after ARP_TIMEOUT cycles.
module ip_tx_arp_resolve #(
    parameter int DATA_WIDTH  = 64,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int ARP_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_ip_hdr_valid,
    output logic                  s_ip_hdr_ready,
    input  logic [5:0]            s_ip_dscp,
    input  logic [1:0]            s_ip_ecn,
    input  logic [15:0]           s_ip_length,
    input  logic [7:0]            s_ip_ttl,
    input  logic [7:0]            s_ip_protocol,
    input  logic [31:0]           s_ip_source_ip,
    input  logic [31:0]           s_ip_dest_ip,
    input  logic [DATA_WIDTH-1:0] s_ip_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_ip_payload_axis_tkeep,
    input  logic                  s_ip_payload_axis_tvalid,
    output logic                  s_ip_payload_axis_tready,
    input  logic                  s_ip_payload_axis_tlast,
    input  logic                  s_ip_payload_axis_tuser,
    output logic                  arp_request_valid,
    input  logic                  arp_request_ready,
    output logic [31:0]           arp_request_ip,
    input  logic                  arp_response_valid,
    output logic                  arp_response_ready,
    input  logic                  arp_response_error,
    input  logic [47:0]           arp_response_mac,
    output logic                  m_ip_hdr_valid,
    input  logic                  m_ip_hdr_ready,
    output logic [47:0]           m_ip_eth_dest_mac,
    output logic [47:0]           m_ip_eth_src_mac,
    output logic [15:0]           m_ip_eth_type,
    output logic [5:0]            m_ip_dscp,
    output logic [1:0]            m_ip_ecn,
    output logic [15:0]           m_ip_length,
    output logic [7:0]            m_ip_ttl,
    output logic [7:0]            m_ip_protocol,
    output logic [31:0]           m_ip_source_ip,
    output logic [31:0]           m_ip_dest_ip,
    output logic [DATA_WIDTH-1:0] m_ip_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_ip_payload_axis_tkeep,
    output logic                  m_ip_payload_axis_tvalid,
    input  logic                  m_ip_payload_axis_tready,
    output logic                  m_ip_payload_axis_tlast,
    output logic                  m_ip_payload_axis_tuser,
    input  logic [47:0]           local_mac,
    output logic                  busy,
    output logic                  error_arp_failed,
    output logic                  error_arp_timeout
);
    typedef enum logic [2:0] {IDLE, ARP_REQ, ARP_WAIT, HDR_OUT, PAYLOAD, DROP} state_t;
    state_t        state_q, state_d;
    logic          hdr_ready_q, hdr_ready_d;
    logic [151:0]  fld_q, fld_d;
    logic [47:0]   dest_mac_q, dest_mac_d;
    logic          err_failed_q, err_failed_d, err_timeout_q, err_timeout_d;
    logic          hdr_hs, resp_hs, last_hs, expired;
    assign hdr_hs  = s_ip_hdr_valid && hdr_ready_q;
    assign resp_hs = (state_q == ARP_WAIT) && arp_response_valid;
    assign last_hs = s_ip_payload_axis_tvalid && s_ip_payload_axis_tready && s_ip_payload_axis_tlast;
`ifdef IP_TX_ARP_TIMEOUT_EN
    localparam int CW = $clog2(ARP_TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_arp;
    assign in_arp  = (state_q == ARP_REQ) || (state_q == ARP_WAIT);
    assign expired = in_arp && (cnt_q == CW'(ARP_TIMEOUT - 1));
    always_comb cnt_d = hdr_hs ? '0 : in_arp ? cnt_q + CW'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_cfg;
    assign unused_cfg = (ARP_TIMEOUT != 0);
    assign expired    = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          if (hdr_hs) state_d = ARP_REQ;
            ARP_REQ:       state_d = expired ? DROP : arp_request_ready ? ARP_WAIT : ARP_REQ;
            ARP_WAIT:      state_d = resp_hs ? (arp_response_error ? DROP : HDR_OUT) : expired ? DROP : ARP_WAIT;
            HDR_OUT:       if (m_ip_hdr_ready) state_d = PAYLOAD;
            PAYLOAD, DROP: if (last_hs) state_d = IDLE;
            default:       state_d = IDLE;
        endcase
        // registered so that ready is low throughout reset and rises on the first IDLE edge
        hdr_ready_d   = (state_d == IDLE);
        fld_d         = hdr_hs ? {local_mac, s_ip_dscp, s_ip_ecn, s_ip_length, s_ip_ttl, s_ip_protocol,
                                  s_ip_source_ip, s_ip_dest_ip} : fld_q;
        dest_mac_d    = (resp_hs && !arp_response_error) ? arp_response_mac : dest_mac_q;
        // a response accepted on the expiry cycle takes priority over the timeout
        err_timeout_d = expired && !resp_hs;
        err_failed_d  = err_timeout_d || (resp_hs && arp_response_error);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hdr_ready_q   <= 1'b0;
            fld_q         <= '0;
            dest_mac_q    <= '0;
            err_failed_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_ready_q   <= hdr_ready_d;
            fld_q         <= fld_d;
            dest_mac_q    <= dest_mac_d;
            err_failed_q  <= err_failed_d;
            err_timeout_q <= err_timeout_d;
        end
    end
    assign {m_ip_eth_src_mac, m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl, m_ip_protocol,
            m_ip_source_ip, m_ip_dest_ip} = fld_q;
    assign m_ip_eth_dest_mac        = dest_mac_q;
    assign m_ip_eth_type            = 16'h0800;
    assign s_ip_hdr_ready           = hdr_ready_q;
    assign arp_request_valid        = (state_q == ARP_REQ);
    assign arp_request_ip           = m_ip_dest_ip;
    assign arp_response_ready       = (state_q == ARP_WAIT);
    assign m_ip_hdr_valid           = (state_q == HDR_OUT);
    assign s_ip_payload_axis_tready = ((state_q == PAYLOAD) && m_ip_payload_axis_tready) || (state_q == DROP);
    assign m_ip_payload_axis_tvalid = (state_q == PAYLOAD) && s_ip_payload_axis_tvalid;
    assign m_ip_payload_axis_tdata  = s_ip_payload_axis_tdata;
    assign m_ip_payload_axis_tkeep  = (KEEP_ENABLE != 0) ? s_ip_payload_axis_tkeep : {KEEP_WIDTH{1'b1}};
    assign m_ip_payload_axis_tlast  = s_ip_payload_axis_tlast;
    assign m_ip_payload_axis_tuser  = s_ip_payload_axis_tuser;
    assign busy                     = (state_q != IDLE);
    assign error_arp_failed         = err_failed_q;
    assign error_arp_timeout        = err_timeout_q;
endmodule

// File: tb/tb_ip_tx_arp_resolve.sv
// tb_ip_tx_arp_resolve: scoreboard bench for ip_tx_arp_resolve (64-bit instance plus 8-bit no-keep instance).
module tb_ip_tx_arp_resolve;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_ip_hdr_valid = 1'b0, s_ip_hdr_ready;
    logic [5:0]  s_ip_dscp = '0;
    logic [1:0]  s_ip_ecn = '0;
    logic [15:0] s_ip_length = '0;
    logic [7:0]  s_ip_ttl = '0, s_ip_protocol = '0;
    logic [31:0] s_ip_source_ip = '0, s_ip_dest_ip = '0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
    logic        arp_request_valid, arp_request_ready = 1'b0;
    logic [31:0] arp_request_ip;
    logic        arp_response_valid = 1'b0, arp_response_ready, arp_response_error = 1'b0;
    logic [47:0] arp_response_mac = '0;
    logic        m_ip_hdr_valid, m_ip_hdr_ready;
    logic [47:0] m_ip_eth_dest_mac, m_ip_eth_src_mac;
    logic [15:0] m_ip_eth_type, m_ip_length;
    logic [5:0]  m_ip_dscp;
    logic [1:0]  m_ip_ecn;
    logic [7:0]  m_ip_ttl, m_ip_protocol;
    logic [31:0] m_ip_source_ip, m_ip_dest_ip;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic [47:0] local_mac = '0;
    logic        busy, error_arp_failed, error_arp_timeout;

    logic tog = 1'b0, tog_bit = 1'b0, mt_en = 1'b1;
    assign m_tready       = tog ? tog_bit : mt_en;
    assign m_ip_hdr_ready = tog_bit;
    initial forever begin
        @(posedge clk);
        #1 tog_bit = ~tog_bit;
    end

    ip_tx_arp_resolve #(.DATA_WIDTH(64), .ARP_TIMEOUT(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready),
        .s_ip_dscp(s_ip_dscp), .s_ip_ecn(s_ip_ecn), .s_ip_length(s_ip_length), .s_ip_ttl(s_ip_ttl),
        .s_ip_protocol(s_ip_protocol), .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
        .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tkeep(s_tkeep),
        .s_ip_payload_axis_tvalid(s_tvalid), .s_ip_payload_axis_tready(s_tready),
        .s_ip_payload_axis_tlast(s_tlast), .s_ip_payload_axis_tuser(s_tuser),
        .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
        .arp_request_ip(arp_request_ip),
        .arp_response_valid(arp_response_valid), .arp_response_ready(arp_response_ready),
        .arp_response_error(arp_response_error), .arp_response_mac(arp_response_mac),
        .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
        .m_ip_eth_dest_mac(m_ip_eth_dest_mac), .m_ip_eth_src_mac(m_ip_eth_src_mac),
        .m_ip_eth_type(m_ip_eth_type), .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn),
        .m_ip_length(m_ip_length), .m_ip_ttl(m_ip_ttl), .m_ip_protocol(m_ip_protocol),
        .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
        .m_ip_payload_axis_tdata(m_tdata), .m_ip_payload_axis_tkeep(m_tkeep),
        .m_ip_payload_axis_tvalid(m_tvalid), .m_ip_payload_axis_tready(m_tready),
        .m_ip_payload_axis_tlast(m_tlast), .m_ip_payload_axis_tuser(m_tuser),
        .local_mac(local_mac), .busy(busy),
        .error_arp_failed(error_arp_failed), .error_arp_timeout(error_arp_timeout)
    );

    // 8-bit instance: no tkeep, all handshakes on the far side held ready
    logic        b_hdr_valid = 1'b0, b_hdr_ready, b_tvalid = 1'b0, b_tready, b_tlast = 1'b0;
    logic [7:0]  b_tdata = '0;
    logic        b_resp_valid = 1'b0, b_resp_ready, b_m_hdr_valid;
    logic [47:0] b_dest_mac;
    logic [7:0]  b_m_tdata;
    logic [0:0]  b_m_tkeep;
    logic        b_m_tvalid, b_m_tlast;
    logic        b_unused_arp_valid, b_unused_tuser, b_unused_busy, b_unused_ef, b_unused_et;
    logic [31:0] b_unused_arp_ip, b_unused_sip, b_unused_dip;
    logic [47:0] b_unused_src_mac;
    logic [15:0] b_unused_type, b_unused_len;
    logic [5:0]  b_unused_dscp;
    logic [1:0]  b_unused_ecn;
    logic [7:0]  b_unused_ttl, b_unused_proto;

    ip_tx_arp_resolve #(.DATA_WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .s_ip_hdr_valid(b_hdr_valid), .s_ip_hdr_ready(b_hdr_ready),
        .s_ip_dscp(6'd0), .s_ip_ecn(2'd0), .s_ip_length(16'd40), .s_ip_ttl(8'd64),
        .s_ip_protocol(8'd17), .s_ip_source_ip(32'h0A000001), .s_ip_dest_ip(32'h0A000002),
        .s_ip_payload_axis_tdata(b_tdata), .s_ip_payload_axis_tkeep(1'b0),
        .s_ip_payload_axis_tvalid(b_tvalid), .s_ip_payload_axis_tready(b_tready),
        .s_ip_payload_axis_tlast(b_tlast), .s_ip_payload_axis_tuser(1'b0),
        .arp_request_valid(b_unused_arp_valid), .arp_request_ready(1'b1),
        .arp_request_ip(b_unused_arp_ip),
        .arp_response_valid(b_resp_valid), .arp_response_ready(b_resp_ready),
        .arp_response_error(1'b0), .arp_response_mac(48'hA1A2A3A4A5A6),
        .m_ip_hdr_valid(b_m_hdr_valid), .m_ip_hdr_ready(1'b1),
        .m_ip_eth_dest_mac(b_dest_mac), .m_ip_eth_src_mac(b_unused_src_mac),
        .m_ip_eth_type(b_unused_type), .m_ip_dscp(b_unused_dscp), .m_ip_ecn(b_unused_ecn),
        .m_ip_length(b_unused_len), .m_ip_ttl(b_unused_ttl), .m_ip_protocol(b_unused_proto),
        .m_ip_source_ip(b_unused_sip), .m_ip_dest_ip(b_unused_dip),
        .m_ip_payload_axis_tdata(b_m_tdata), .m_ip_payload_axis_tkeep(b_m_tkeep),
        .m_ip_payload_axis_tvalid(b_m_tvalid), .m_ip_payload_axis_tready(1'b1),
        .m_ip_payload_axis_tlast(b_m_tlast), .m_ip_payload_axis_tuser(b_unused_tuser),
        .local_mac(48'h020000000008), .busy(b_unused_busy),
        .error_arp_failed(b_unused_ef), .error_arp_timeout(b_unused_et)
    );

    int compared = 0, mismatched = 0;
    int n_failed = 0, n_timeout = 0, b_hdr_seen = 0, cyc = 0, hs_cyc = 0, err_cyc = 0;
    logic [215:0] hdr_q[$];
    logic [73:0]  beat_q[$];
    logic [31:0]  ip_q[$];
    logic [9:0]   b_beat_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: handshake not seen within cycle budget", name);
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] bdata(input logic [7:0] seed, input int i);
        return {8{seed + 8'(i)}};
    endfunction

    function automatic logic [7:0] bkeep(input int i, input int n);
        return (i == n - 1) ? 8'h0F : 8'hFF;
    endfunction

    function automatic logic [215:0] exp_hdr(input logic [31:0] dip, input logic [15:0] len, input logic [47:0] mac);
        return {mac, 16'h0200, dip, 16'h0800, len[5:0], len[7:6], len, len[7:0] ^ 8'h40, 8'h11,
                dip ^ 32'h0A000001, dip};
    endfunction

    // monitor: pops the scoreboard whenever the DUT completes an output handshake
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (s_ip_hdr_valid && s_ip_hdr_ready) hs_cyc = cyc;
            if (arp_request_valid && arp_request_ready)
                chk("arp_request_ip", arp_request_ip, ip_q.size() ? ip_q.pop_front() : 'x);
            if (m_ip_hdr_valid && m_ip_hdr_ready)
                chk("m_hdr", {m_ip_eth_dest_mac, m_ip_eth_src_mac, m_ip_eth_type, m_ip_dscp, m_ip_ecn,
                              m_ip_length, m_ip_ttl, m_ip_protocol, m_ip_source_ip, m_ip_dest_ip},
                    hdr_q.size() ? hdr_q.pop_front() : 'x);
            if (m_tvalid) chk("s_tready_tracks_m", s_tready, m_tready);
            if (m_tvalid && m_tready)
                chk("m_beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, beat_q.size() ? beat_q.pop_front() : 'x);
            if (error_arp_failed) n_failed++;
            if (error_arp_timeout) begin
                n_timeout++;
                err_cyc = cyc;
            end
            if (b_m_hdr_valid) begin
                b_hdr_seen++;
                chk("b_eth_dest_mac", b_dest_mac, 48'hA1A2A3A4A5A6);
            end
            if (b_m_tvalid)
                chk("b_beat", {b_m_tdata, b_m_tkeep, b_m_tlast}, b_beat_q.size() ? b_beat_q.pop_front() : 'x);
        end
    end

    task automatic hdr_send(input logic [31:0] dip, input logic [15:0] len);
        int k = 0;
        s_ip_dest_ip   = dip;
        s_ip_length    = len;
        s_ip_dscp      = len[5:0];
        s_ip_ecn       = len[7:6];
        s_ip_ttl       = len[7:0] ^ 8'h40;
        s_ip_protocol  = 8'h11;
        s_ip_source_ip = dip ^ 32'h0A000001;
        local_mac      = {16'h0200, dip};
        s_ip_hdr_valid = 1'b1;
        do begin @(negedge clk); k++; end while (!s_ip_hdr_ready && k < 300);
        if (!s_ip_hdr_ready) tmo("hdr_accept");
        @(posedge clk);
        #1;
        s_ip_hdr_valid = 1'b0;
        s_ip_dest_ip   = ~dip;
        s_ip_length    = ~len;
        local_mac      = '1;
    endtask

    task automatic arp_serve(input logic err, input logic [47:0] mac, input logic respond);
        int k = 0;
        do begin @(negedge clk); k++; end while (!arp_request_valid && k < 300);
        if (!arp_request_valid) tmo("arp_request");
        cyc_wait(2);
        arp_request_ready = 1'b1;
        @(posedge clk);
        #1 arp_request_ready = 1'b0;
        if (respond) begin
            cyc_wait(2);
            arp_response_valid = 1'b1;
            arp_response_error = err;
            arp_response_mac   = mac;
            k = 0;
            do begin @(negedge clk); k++; end while (!arp_response_ready && k < 300);
            if (!arp_response_ready) tmo("arp_response");
            @(posedge clk);
            #1 arp_response_valid = 1'b0;
        end
    endtask

    task automatic beat_wait(input string nm);
        int k = 0;
        do begin @(negedge clk); k++; end while (!s_tready && k < 300);
        if (!s_tready) tmo(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic pay_send(input int n, input logic [7:0] seed);
        for (int i = 0; i < n; i++) begin
            s_tdata  = bdata(seed, i);
            s_tkeep  = bkeep(i, n);
            s_tlast  = (i == n - 1);
            s_tuser  = (i == 1);
            s_tvalid = 1'b1;
            beat_wait("payload_beat");
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic frame(input logic [31:0] dip, input logic [15:0] len, input logic [47:0] mac,
                         input logic err, input logic respond, input int n, input logic [7:0] seed);
        ip_q.push_back(dip);
        if (respond && !err) begin
            hdr_q.push_back(exp_hdr(dip, len, mac));
            for (int i = 0; i < n; i++)
                beat_q.push_back({bdata(seed, i), bkeep(i, n), 1'(i == n - 1), 1'(i == 1)});
        end
        fork
            hdr_send(dip, len);
            arp_serve(err, mac, respond);
            pay_send(n, seed);
        join
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #12;
        chk("rst_hdr_ready", s_ip_hdr_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_arp_req_valid", arp_request_valid, 1'b0);
        chk("rst_m_hdr_valid", m_ip_hdr_valid, 1'b0);
        chk("rst_errors", {error_arp_failed, error_arp_timeout}, 2'b00);
        chk("rst_dest_ip", m_ip_dest_ip, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("hdr_ready_after_rst", s_ip_hdr_ready, 1'b1);

        // resolved frame: FF beat then 0F beat
        frame(32'hC0A80102, 16'd28, 48'h5A5152535455, 1'b0, 1'b1, 2, 8'h10);
        cyc_wait(2);
        chk("t1_busy_idle", busy, 1'b0);
        chk("t1_no_error", n_failed, 0);

        // ARP error: single pulse, payload swallowed
        frame(32'hC0A80103, 16'd44, 48'h5A0000000002, 1'b1, 1'b1, 3, 8'h20);
        cyc_wait(3);
        chk("t2_failed_pulses", n_failed, 1);
        chk("t2_busy_idle", busy, 1'b0);

        // output backpressure toggling every cycle
        tog = 1'b1;
        frame(32'hC0A80104, 16'd60, 48'h5A0000000003, 1'b0, 1'b1, 6, 8'h30);
        tog = 1'b0;
        cyc_wait(2);

`ifdef IP_TX_ARP_TIMEOUT_EN
        frame(32'hC0A80105, 16'd30, 48'h0, 1'b0, 1'b0, 2, 8'h40);
        cyc_wait(3);
        chk("t5_failed_pulses", n_failed, 2);
        chk("t5_timeout_pulses", n_timeout, 1);
        chk("t5_timeout_latency", err_cyc - hs_cyc, 17);
        frame(32'hC0A80106, 16'd32, 48'h5A0000000005, 1'b0, 1'b1, 2, 8'h50);
        cyc_wait(2);
`endif

        // reset asserted while beat 2 is presented
        ip_q.push_back(32'hC0A80199);
        hdr_q.push_back(exp_hdr(32'hC0A80199, 16'd40, 48'h5A0000000006));
        beat_q.push_back({bdata(8'h70, 0), 8'hFF, 1'b0, 1'b0});
        fork
            hdr_send(32'hC0A80199, 16'd40);
            arp_serve(1'b0, 48'h5A0000000006, 1'b1);
            begin
                s_tdata  = bdata(8'h70, 0);
                s_tkeep  = 8'hFF;
                s_tlast  = 1'b0;
                s_tuser  = 1'b0;
                s_tvalid = 1'b1;
                beat_wait("t6_beat1");
                mt_en   = 1'b0;
                s_tdata = bdata(8'h70, 1);
            end
        join
        @(negedge clk);
        chk("t6_beat2_presented", m_tvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_m_tvalid", m_tvalid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_hdr_ready", s_ip_hdr_ready, 1'b0);
        chk("t6_rst_s_tready", s_tready, 1'b0);
        s_tvalid = 1'b0;
        mt_en    = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("t6_hdr_ready_after_rst", s_ip_hdr_ready, 1'b1);

        // 8-bit no-keep instance: 20 single-byte beats
        for (int i = 0; i < 20; i++) b_beat_q.push_back({8'hB0 + 8'(i), 1'b1, 1'(i == 19)});
        fork
            begin
                int k = 0;
                b_hdr_valid = 1'b1;
                do begin @(negedge clk); k++; end while (!b_hdr_ready && k < 300);
                if (!b_hdr_ready) tmo("b_hdr_accept");
                @(posedge clk);
                #1 b_hdr_valid = 1'b0;
            end
            begin
                int k = 0;
                b_resp_valid = 1'b1;
                do begin @(negedge clk); k++; end while (!b_resp_ready && k < 300);
                if (!b_resp_ready) tmo("b_arp_response");
                @(posedge clk);
                #1 b_resp_valid = 1'b0;
            end
            for (int i = 0; i < 20; i++) begin
                int k = 0;
                b_tdata  = 8'hB0 + 8'(i);
                b_tlast  = (i == 19);
                b_tvalid = 1'b1;
                do begin @(negedge clk); k++; end while (!b_tready && k < 300);
                if (!b_tready) tmo("b_beat_accept");
                @(posedge clk);
                #1 b_tvalid = 1'b0;
            end
        join
        cyc_wait(3);
        chk("b_hdr_count", b_hdr_seen, 1);
        chk("b_beats_drained", b_beat_q.size(), 0);

`ifndef IP_TX_ARP_TIMEOUT_EN
        chk("timeout_pulse_absent", n_timeout, 0);
`endif
        chk("hdr_q_drained", hdr_q.size(), 0);
        chk("beat_q_drained", beat_q.size(), 0);
        chk("ip_q_drained", ip_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
